// File: rtl/pwmtimer_update_ctrl.sv
// pwmtimer_update_ctrl: run/stop sequencer and shadow-register update
// scheduler for one pwmtimer_16bits. New carrier configuration is held in a
// shadow and only copied to the timer on a carrier sync event (or at once in
// IDLE), so countmax/count_mode never change in the middle of a period.
module pwmtimer_update_ctrl #(
  parameter int unsigned    CW      = 16,
  parameter int unsigned    DIVW    = 8,
  parameter logic [CW-1:0]  DEF_MAX = 16'h00FF
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            cfg_valid_i,
  output logic            cfg_ready_o,
  input  logic [CW-1:0]   cfg_countmax_i,
  input  logic [CW-1:0]   cfg_init_i,
  input  logic [1:0]      cfg_mode_i,
  input  logic [1:0]      cfg_syncmode_i,
  input  logic [DIVW-1:0] cfg_upd_div_i,
  input  logic            start_i,
  input  logic            stop_i,
  input  logic            tmr_sync_i,
  output logic            tmr_rst_o,
  output logic            tmr_ce_o,
  output logic [CW-1:0]   tmr_countmax_o,
  output logic [CW-1:0]   tmr_init_o,
  output logic [1:0]      tmr_mode_o,
  output logic [1:0]      tmr_syncmode_o,
  output logic            running_o,
  output logic            upd_done_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_STOP
  } state_e;

  state_e          state_q, state_d;
  logic            tmr_rst_q, tmr_ce_q, running_q;

  logic            pending_q;
  logic [DIVW-1:0] sync_cnt_q;
  logic [CW-1:0]   sh_countmax_q, sh_init_q;
  logic [1:0]      sh_mode_q, sh_syncmode_q;
  logic [DIVW-1:0] sh_div_q;

  logic [CW-1:0]   tmr_countmax_q, tmr_init_q;
  logic [1:0]      tmr_mode_q, tmr_syncmode_q;
  logic            upd_done_q;

  logic            accept;
  logic            sync_hit;
  logic            apply;

  // The shadow is free whenever nothing is waiting to be applied.
  assign cfg_ready_o = ~pending_q;
  assign accept      = cfg_valid_i & ~pending_q;
  // Syncs only advance the divider while running with an update waiting.
  assign sync_hit    = (state_q == S_RUN) & pending_q & tmr_sync_i;
  assign apply       = pending_q &
                       ((state_q == S_IDLE) | (sync_hit & (sync_cnt_q == sh_div_q)));

  // Next-state decision for the run/stop sequencer.
  always_comb begin
    // NOTE: default assignment first so every path drives state_d; otherwise a latch is inferred.
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start_i && !stop_i) state_d = S_LOAD;
      S_LOAD: state_d = stop_i ? S_IDLE : S_RUN;
      S_RUN:  if (stop_i) state_d = S_STOP;
      S_STOP: if (tmr_sync_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register with timer controls decoded from the destination state,
  // so the outputs are registered and line up with the state they belong to.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      // NOTE: sequential state always uses non-blocking assignments so every register samples pre-edge values.
      state_q   <= S_IDLE;
      tmr_rst_q <= 1'b1;
      tmr_ce_q  <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmr_rst_q <= (state_d == S_IDLE) || (state_d == S_LOAD);
      tmr_ce_q  <= (state_d != S_IDLE);
      running_q <= (state_d == S_RUN) || (state_d == S_STOP);
    end
  end

  // Shadow capture, pending flag and update divider.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      // NOTE: the shadow is reset too, so a reset always discards a pending update and leaves no X in flight.
      pending_q     <= 1'b0;
      sync_cnt_q    <= '0;
      sh_countmax_q <= '0;
      sh_init_q     <= '0;
      sh_mode_q     <= '0;
      sh_syncmode_q <= '0;
      sh_div_q      <= '0;
    end else if (accept) begin
      pending_q     <= 1'b1;
      sync_cnt_q    <= '0;
      sh_countmax_q <= cfg_countmax_i;
      sh_init_q     <= cfg_init_i;
      sh_mode_q     <= cfg_mode_i;
      sh_syncmode_q <= cfg_syncmode_i;
      sh_div_q      <= cfg_upd_div_i;
    end else if (apply) begin
      pending_q     <= 1'b0;
      sync_cnt_q    <= '0;
    end else if (sync_hit) begin
      sync_cnt_q    <= sync_cnt_q + 1'b1;
    end
  end

  // Applied configuration seen by the timer, plus the one-cycle done pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tmr_countmax_q <= DEF_MAX;
      tmr_init_q     <= '0;
      tmr_mode_q     <= 2'b00;
      tmr_syncmode_q <= 2'd3;
      upd_done_q     <= 1'b0;
    end else begin
      upd_done_q <= apply;
      if (apply) begin
        tmr_countmax_q <= sh_countmax_q;
        tmr_init_q     <= sh_init_q;
        tmr_mode_q     <= sh_mode_q;
        tmr_syncmode_q <= sh_syncmode_q;
      end
    end
  end

  assign tmr_rst_o      = tmr_rst_q;
  assign tmr_ce_o       = tmr_ce_q;
  assign running_o      = running_q;
  assign tmr_countmax_o = tmr_countmax_q;
  assign tmr_init_o     = tmr_init_q;
  assign tmr_mode_o     = tmr_mode_q;
  assign tmr_syncmode_o = tmr_syncmode_q;
  assign upd_done_o     = upd_done_q;

endmodule

// File: tb/tb_pwmtimer_update_ctrl.sv
// Testbench for pwmtimer_update_ctrl: directed vectors, expected applied
// configurations pushed to a scoreboard queue and popped by a monitor on
// every upd_done pulse; sequencing outputs checked directly.
module tb_pwmtimer_update_ctrl;

  localparam int CW   = 16;
  localparam int DIVW = 8;

  typedef struct packed {
    logic [CW-1:0] countmax;
    logic [CW-1:0] init;
    logic [1:0]    mode;
    logic [1:0]    syncmode;
  } cfg_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            cfg_valid, cfg_ready;
  logic [CW-1:0]   cfg_countmax, cfg_init;
  logic [1:0]      cfg_mode, cfg_syncmode;
  logic [DIVW-1:0] cfg_upd_div;
  logic            start, stop, tmr_sync;
  logic            tmr_rst, tmr_ce, running, upd_done;
  logic [CW-1:0]   tmr_countmax, tmr_init;
  logic [1:0]      tmr_mode, tmr_syncmode;

  int   n_checks = 0;
  int   n_fail   = 0;
  cfg_t exp_q[$];

  always #5 clk = ~clk;

  pwmtimer_update_ctrl #(.CW(CW), .DIVW(DIVW), .DEF_MAX(16'h00FF)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .cfg_valid_i    (cfg_valid),
    .cfg_ready_o    (cfg_ready),
    .cfg_countmax_i (cfg_countmax),
    .cfg_init_i     (cfg_init),
    .cfg_mode_i     (cfg_mode),
    .cfg_syncmode_i (cfg_syncmode),
    .cfg_upd_div_i  (cfg_upd_div),
    .start_i        (start),
    .stop_i         (stop),
    .tmr_sync_i     (tmr_sync),
    .tmr_rst_o      (tmr_rst),
    .tmr_ce_o       (tmr_ce),
    .tmr_countmax_o (tmr_countmax),
    .tmr_init_o     (tmr_init),
    .tmr_mode_o     (tmr_mode),
    .tmr_syncmode_o (tmr_syncmode),
    .running_o      (running),
    .upd_done_o     (upd_done)
  );

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Advance to just after the next rising edge; inputs change and outputs are sampled here.
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Offer a configuration for one cycle; push the expected result if it is accepted.
  task automatic offer(input cfg_t c, input logic [DIVW-1:0] div, input bit expect_accept);
    cfg_valid    = 1'b1;
    cfg_countmax = c.countmax;
    cfg_init     = c.init;
    cfg_mode     = c.mode;
    cfg_syncmode = c.syncmode;
    cfg_upd_div  = div;
    check("cfg_ready_at_offer", {31'd0, cfg_ready}, {31'd0, expect_accept});
    if (expect_accept) exp_q.push_back(c);
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic sync_pulse();
    tmr_sync = 1'b1;
    tick();
    tmr_sync = 1'b0;
  endtask

  task automatic check_ctl(input string name, input logic r, input logic ce, input logic run);
    check({name, "_tmr_rst"}, {31'd0, tmr_rst}, {31'd0, r});
    check({name, "_tmr_ce"},  {31'd0, tmr_ce},  {31'd0, ce});
    check({name, "_running"}, {31'd0, running}, {31'd0, run});
  endtask

  task automatic check_reset_vals(input string name);
    check_ctl(name, 1'b1, 1'b0, 1'b0);
    check({name, "_countmax"}, {16'd0, tmr_countmax}, 32'h00FF);
    check({name, "_init"},     {16'd0, tmr_init},     32'h0);
    check({name, "_mode"},     {30'd0, tmr_mode},     32'h0);
    check({name, "_syncmode"}, {30'd0, tmr_syncmode}, 32'h3);
    check({name, "_upd_done"}, {31'd0, upd_done},     32'h0);
    check({name, "_cfg_ready"},{31'd0, cfg_ready},    32'h1);
  endtask

  // Scoreboard monitor: every upd_done pulse must match the oldest expected configuration.
  always @(negedge clk) begin
    if (rst_n && upd_done) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_upd_done", 32'd1, 32'd0);
      end else begin
        cfg_t e;
        e = exp_q.pop_front();
        check("sb_countmax", {16'd0, tmr_countmax}, {16'd0, e.countmax});
        check("sb_init",     {16'd0, tmr_init},     {16'd0, e.init});
        check("sb_mode",     {30'd0, tmr_mode},     {30'd0, e.mode});
        check("sb_syncmode", {30'd0, tmr_syncmode}, {30'd0, e.syncmode});
      end
    end
  end

  initial begin
    cfg_t c;
    rst_n = 1'b0; cfg_valid = 1'b0; cfg_countmax = '0; cfg_init = '0;
    cfg_mode = '0; cfg_syncmode = '0; cfg_upd_div = '0;
    start = 1'b0; stop = 1'b0; tmr_sync = 1'b0;
    #23;
    check_reset_vals("reset");
    rst_n = 1'b1;
    tick();

    // 1: configuration in IDLE applies one cycle after acceptance.
    c = '{countmax: 16'h00FF, init: 16'h0010, mode: 2'b11, syncmode: 2'b01};
    offer(c, 8'd0, 1'b1);
    check("t1_ready_low", {31'd0, cfg_ready}, 32'd0);
    check("t1_no_done_yet", {31'd0, upd_done}, 32'd0);
    tick();
    check("t1_upd_done", {31'd0, upd_done}, 32'd1);
    check("t1_countmax", {16'd0, tmr_countmax}, 32'h00FF);
    check("t1_mode", {30'd0, tmr_mode}, 32'h3);
    check("t1_ready_back", {31'd0, cfg_ready}, 32'd1);
    tick();
    check("t1_done_one_cycle", {31'd0, upd_done}, 32'd0);

    // start together with stop in IDLE is ignored.
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    check_ctl("idle_start_stop", 1'b1, 1'b0, 1'b0);

    // 2: start -> one LOAD cycle -> RUN.
    start = 1'b1;
    tick();
    start = 1'b0;
    check_ctl("t2_load", 1'b1, 1'b1, 1'b0);
    tick();
    check_ctl("t2_run", 1'b0, 1'b1, 1'b1);
    tick();
    check_ctl("t2_run_hold", 1'b0, 1'b1, 1'b1);

    // 3: update with div=2 applies only after the third sync.
    c = '{countmax: 16'h0080, init: 16'h0005, mode: 2'b10, syncmode: 2'b10};
    offer(c, 8'd2, 1'b1);
    // Keep offering a different configuration; it must not be taken.
    cfg_valid = 1'b1; cfg_countmax = 16'h0040; cfg_upd_div = 8'd0;
    for (int k = 0; k < 2; k++) begin
      sync_pulse();
      check("t3_hold_countmax", {16'd0, tmr_countmax}, 32'h00FF);
      check("t3_ready_low", {31'd0, cfg_ready}, 32'd0);
      tick(2);
      check("t3_no_done", {31'd0, upd_done}, 32'd0);
    end
    cfg_valid = 1'b0;
    sync_pulse();
    check("t3_upd_done", {31'd0, upd_done}, 32'd1);
    check("t3_countmax", {16'd0, tmr_countmax}, 32'h0080);
    check("t3_ready_back", {31'd0, cfg_ready}, 32'd1);
    tick();

    // 4: stop in RUN keeps the timer running until the next sync.
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check_ctl("t4_stop", 1'b0, 1'b1, 1'b1);
    tick(3);
    check_ctl("t4_stop_hold", 1'b0, 1'b1, 1'b1);

    // 5: configuration accepted in STOP waits for IDLE.
    c = '{countmax: 16'h0033, init: 16'h0001, mode: 2'b01, syncmode: 2'b11};
    offer(c, 8'd0, 1'b1);
    tick(2);
    check("t5_no_apply_stop", {16'd0, tmr_countmax}, 32'h0080);
    check("t5_no_done_stop", {31'd0, upd_done}, 32'd0);
    sync_pulse();
    check_ctl("t5_idle", 1'b1, 1'b0, 1'b0);
    check("t5_not_yet", {16'd0, tmr_countmax}, 32'h0080);
    tick();
    check("t5_upd_done", {31'd0, upd_done}, 32'd1);
    check("t5_countmax", {16'd0, tmr_countmax}, 32'h0033);
    tick();

    // 6: asynchronous reset while an update is pending in RUN.
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check_ctl("t6_run", 1'b0, 1'b1, 1'b1);
    c = '{countmax: 16'h0099, init: 16'h0002, mode: 2'b11, syncmode: 2'b01};
    offer(c, 8'd5, 1'b1);
    void'(exp_q.pop_back());   // this update will be discarded by reset
    check("t6_pending", {31'd0, cfg_ready}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check_reset_vals("t6_reset");
    #1 rst_n = 1'b1;
    tick(3);
    check("t6_no_upd_done", {31'd0, upd_done}, 32'd0);
    check("t6_countmax_default", {16'd0, tmr_countmax}, 32'h00FF);
    check_ctl("t6_idle", 1'b1, 1'b0, 1'b0);

    check("sb_queue_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard bound so the run always ends.
  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
